ace_video_fetch: RTL and testbench

- Display-timing and fetch engine for the Jupiter Ace video path.
- Reads the screen RAM through the video read port of the dual-port 1K screen RAM, then reads the 1K character-set RAM.
- Serialises each glyph row into one monochrome pixel stream with sync and blanking.
- Sits directly downstream of both video RAMs; output goes to the board video encoder.

---
 rtl/ace_video_fetch.sv | 148 ++++++++++++++
 tb/tb_ace_video_fetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ace_video_fetch.sv
// ace_video_fetch: Jupiter Ace display timing, screen/character RAM fetch and
// monochrome pixel serialiser with sync, blanking and frame interrupt.
module ace_video_fetch #(
    parameter int unsigned H_TOTAL      = 416,
    parameter int unsigned V_TOTAL      = 312,
    parameter int unsigned H_SYNC_START = 320,
    parameter int unsigned H_SYNC_LEN   = 32,
    parameter int unsigned V_SYNC_START = 248,
    parameter int unsigned V_SYNC_LEN   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    output logic [9:0] scr_addr,
    input  logic [7:0] scr_data,
    output logic [9:0] chr_addr,
    input  logic [7:0] chr_data,
    output logic       pixel,
    output logic       blank,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_irq
);

    localparam int unsigned CNT_W    = 9;
    localparam int unsigned ACT_W    = 256;
    localparam int unsigned ACT_H    = 192;
    localparam int unsigned PIPE_DLY = 8;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(ACT_W);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(ACT_H);
    localparam logic [CNT_W-1:0] BLK_START = CNT_W'(PIPE_DLY);
    localparam logic [CNT_W-1:0] BLK_END   = CNT_W'(ACT_W + PIPE_DLY);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_SYNC_START);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_SYNC_START + V_SYNC_LEN);
    localparam logic [CNT_W-1:0] IRQ_LINE  = CNT_W'(ACT_H);

    // Cell phases: address screen RAM, address char RAM, take glyph, load shifter.
    localparam logic [2:0] PH_SCR   = 3'd0;
    localparam logic [2:0] PH_CHR   = 3'd2;
    localparam logic [2:0] PH_GLYPH = 3'd4;
    localparam logic [2:0] PH_LOAD  = 3'd7;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic [2:0]       phase_c;
    logic             fetch_act_c;
    logic             disp_act_c;
    logic             hsync_c;
    logic             vsync_c;
    logic             inv;
    logic             inv_out;
    logic [7:0]       glyph;
    logic [7:0]       shifter;

    // Window and sync decode from the counters as they stand at the next pix_ce edge.
    always_comb begin
        phase_c     = hcount[2:0];
        fetch_act_c = (hcount < H_ACT_END) && (vcount < V_ACT_END);
        disp_act_c  = (hcount >= BLK_START) && (hcount < BLK_END) && (vcount < V_ACT_END);
        hsync_c     = (hcount >= HS_START) && (hcount < HS_END);
        vsync_c     = (vcount >= VS_START) && (vcount < VS_END);
    end

    // Horizontal/vertical position counters, advancing only on pix_ce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_ce) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
            end else begin
                hcount <= hcount + CNT_W'(1);
            end
        end
    end

    // Per-cell fetch: addresses stay frozen outside the active window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scr_addr <= '0;
            chr_addr <= '0;
            inv      <= 1'b0;
            glyph    <= '0;
        end else if (pix_ce && fetch_act_c) begin
            case (phase_c)
                PH_SCR: begin
                    scr_addr <= {vcount[7:3], hcount[7:3]};
                end
                PH_CHR: begin
                    inv      <= scr_data[7];
                    chr_addr <= {scr_data[6:0], vcount[2:0]};
                end
                PH_GLYPH: begin
                    glyph <= chr_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Pixel shifter: loaded at the last phase of a cell, otherwise shifts left every pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shifter <= '0;
            inv_out <= 1'b0;
        end else if (pix_ce) begin
            if (fetch_act_c && (phase_c == PH_LOAD)) begin
                shifter <= glyph;
                inv_out <= inv;
            end else begin
                shifter <= {shifter[6:0], 1'b0};
            end
        end
    end

    // Registered video outputs; pixel is forced black whenever blanked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel   <= 1'b0;
            blank   <= 1'b1;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
        end else if (pix_ce) begin
            pixel   <= disp_act_c & (shifter[7] ^ inv_out);
            blank   <= ~disp_act_c;
            hsync_n <= ~hsync_c;
            vsync_n <= ~vsync_c;
        end
    end

    // One-clk frame interrupt at the first pixel edge of the first non-active line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_irq <= 1'b0;
        end else begin
            frame_irq <= pix_ce && (hcount == '0) && (vcount == IRQ_LINE);
        end
    end

endmodule

// File: tb/tb_ace_video_fetch.sv
// tb_ace_video_fetch: scoreboard bench for ace_video_fetch with RAM models and
// a frame-position reference model. Frame height is shortened to keep runtime low.
module tb_ace_video_fetch;

    localparam int unsigned HT  = 416;
    localparam int unsigned VT  = 196;
    localparam int unsigned HSS = 320;
    localparam int unsigned HSL = 32;
    localparam int unsigned VSS = 193;
    localparam int unsigned VSL = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_ce = 1'b0;
    logic [9:0] scr_addr;
    logic [7:0] scr_data;
    logic [9:0] chr_addr;
    logic [7:0] chr_data;
    logic       pixel, blank, hsync_n, vsync_n, frame_irq;

    ace_video_fetch #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
    ) dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .scr_addr(scr_addr), .scr_data(scr_data),
        .chr_addr(chr_addr), .chr_data(chr_data),
        .pixel(pixel), .blank(blank), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .frame_irq(frame_irq)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAMs: one clk from address to data.
    logic [7:0] scr_mem [1024];
    logic [7:0] chr_mem [1024];
    always @(posedge clk) begin
        scr_data <= scr_mem[scr_addr];
        chr_data <= chr_mem[chr_addr];
    end

    typedef struct {
        logic [9:0] scr;
        logic [9:0] chr;
        logic       pix;
        logic       blk;
        logic       hs;
        logic       vs;
        logic       irq;
        logic       ce;
        int         h;
        int         v;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   mh, mv;
    int   mx, ma, mc, mg;
    int   total = 0;
    int   bad = 0;
    int   tphase = 0;

    // Reference model: expected outputs from frame position and RAM contents.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mh = 0; mv = 0;
            cur.scr = '0; cur.chr = '0; cur.pix = 1'b0; cur.blk = 1'b1;
            cur.hs = 1'b1; cur.vs = 1'b1; cur.irq = 1'b0; cur.ce = 1'b0;
            cur.h = -1; cur.v = -1;
            exp_q.delete();
            exp_q.push_back(cur);
        end else begin
            cur.irq = 1'b0;
            cur.ce  = pix_ce;
            if (pix_ce) begin
                cur.h = mh; cur.v = mv;
                cur.blk = !(mh >= 8 && mh < 264 && mv < 192);
                if (cur.blk) begin
                    cur.pix = 1'b0;
                end else begin
                    mx = mh - 8;
                    ma = (mv / 8) * 32 + mx / 8;
                    mc = int'(scr_mem[ma]);
                    mg = int'(chr_mem[(mc % 128) * 8 + mv % 8]);
                    cur.pix = 1'(((mg >> (7 - mx % 8)) ^ (mc >> 7)) & 1);
                end
                cur.hs  = !(mh >= HSS && mh < HSS + HSL);
                cur.vs  = !(mv >= VSS && mv < VSS + VSL);
                cur.irq = (mh == 0 && mv == 192);
                if (mh < 256 && mv < 192) begin
                    if (mh % 8 == 0)
                        cur.scr = 10'((mv / 8) * 32 + mh / 8);
                    if (mh % 8 == 2)
                        cur.chr = 10'((int'(scr_mem[(mv / 8) * 32 + mh / 8]) % 128) * 8 + mv % 8);
                end
                mh = mh + 1;
                if (mh == HT) begin
                    mh = 0;
                    mv = (mv + 1 == VT) ? 0 : mv + 1;
                end
            end
            exp_q.push_back(cur);
        end
    end

    // Taps collected by the monitor for directed checks.
    logic [7:0] cap_n = '0, cap_i = '0;
    logic [9:0] tap_scr = '0, tap_chr = '0;
    int ones_cnt = 0, ones_min = 9999, ones_max = -1;
    int hs_low = 0, hs_first = -1, vs_lines = 0, irq_cnt = 0, line0_cnt = 0;

    exp_t e;
    logic [24:0] act_v, exp_v;

    // Monitor: pops one expectation per clk and compares all outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_v = {scr_addr, chr_addr, pixel, blank, hsync_n, vsync_n, frame_irq};
            exp_v = {e.scr, e.chr, e.pix, e.blk, e.hs, e.vs, e.irq};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL scoreboard t=%0t h=%0d v=%0d actual{scr,chr,pix,blk,hs,vs,irq}=%h required=%h",
                         $time, e.h, e.v, act_v, exp_v);
                if (bad >= 60) begin
                    $display("test done: total=%0d bad=%0d", total, bad);
                    $finish;
                end
            end
            if (tphase == 1 && e.ce && e.v == 0 && pixel) begin
                ones_cnt++;
                if (e.h < ones_min) ones_min = e.h;
                if (e.h > ones_max) ones_max = e.h;
            end
            if (tphase == 2 && e.ce) begin
                if (e.v == 11 && e.h >= 16 && e.h < 24) cap_n[23 - e.h] = pixel;
                if (e.v == 11 && e.h >= 24 && e.h < 32) cap_i[31 - e.h] = pixel;
                if (e.v == 11 && e.h == 8)  tap_scr = scr_addr;
                if (e.v == 11 && e.h == 10) tap_chr = chr_addr;
                if (e.v == 5 && !hsync_n) begin
                    if (hs_low == 0) hs_first = e.h;
                    hs_low++;
                end
                if (e.h == 0 && !vsync_n) vs_lines++;
                if (e.h == 0 && e.v == 0) line0_cnt++;
            end
            if (tphase == 2 && frame_irq) irq_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_scr_addr"}, 32'(scr_addr), 32'h0);
        chk({pfx, "_chr_addr"}, 32'(chr_addr), 32'h0);
        chk({pfx, "_pixel"}, 32'(pixel), 32'h0);
        chk({pfx, "_blank"}, 32'(blank), 32'h1);
        chk({pfx, "_hsync_n"}, 32'(hsync_n), 32'h1);
        chk({pfx, "_vsync_n"}, 32'(vsync_n), 32'h1);
        chk({pfx, "_frame_irq"}, 32'(frame_irq), 32'h0);
    endtask

    initial begin
        // Slow-rate section: all-ones glyphs, no inverse, so the window shows as solid white.
        for (int i = 0; i < 1024; i++) begin
            scr_mem[i] = 8'($urandom) & 8'h7F;
            chr_mem[i] = 8'hFF;
        end
        repeat (3) @(posedge clk);
        #1 chk_reset("por");
        @(posedge clk);
        #2 reset = 1'b0;
        tphase = 1;
        for (int n = 0; n < (2 * HT + 100) * 3; n++) begin
            @(posedge clk);
            #2 pix_ce = (n % 3 == 2);
        end

        // Reset in the middle of line 2: outputs must clear before the next edge.
        @(posedge clk);
        #2 reset = 1'b1;
        pix_ce = 1'b0;
        #1 chk_reset("midreset");
        chk("blank_ones_count", 32'(ones_cnt), 32'd256);
        chk("blank_ones_first_h", 32'(ones_min), 32'd8);
        chk("blank_ones_last_h", 32'(ones_max), 32'd263);

        for (int i = 0; i < 1024; i++) begin
            scr_mem[i] = 8'($urandom);
            chr_mem[i] = 8'($urandom);
        end
        scr_mem[10'h021] = 8'h41;
        scr_mem[10'h022] = 8'hC1;
        chr_mem[10'h20B] = 8'hA5;
        tphase = 2;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        pix_ce = 1'b1;

        // Full-rate frame.
        @(posedge clk);
        #1 chk("scr_addr_h0", 32'(scr_addr), 32'h0);
        repeat (7) @(posedge clk);
        #1 chk("blank_after_h7", 32'(blank), 32'h1);
        @(posedge clk);
        #1 chk("blank_after_h8", 32'(blank), 32'h0);
        repeat (HT * VT + 20 - 9) @(posedge clk);
        @(negedge clk);
        #1;
        chk("cell_pixels", 32'(cap_n), 32'hA5);
        chk("cell_pixels_inverse", 32'(cap_i), 32'h5A);
        chk("scr_addr_line11_h8", 32'(tap_scr), 32'h021);
        chk("chr_addr_line11_h10", 32'(tap_chr), 32'h20B);
        chk("hsync_low_width", 32'(hs_low), 32'(HSL));
        chk("hsync_low_start", 32'(hs_first), 32'(HSS));
        chk("vsync_low_lines", 32'(vs_lines), 32'(VSL));
        chk("frame_irq_pulses", 32'(irq_cnt), 32'd1);
        chk("frame_wraps_to_line0", 32'(line0_cnt), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
